// File: rtl/filter_loader.sv
// Streams one DEPTH_F x DEPTH_F filter from a byte source into wmem's load_start/addr/data/load_done channels.
// Latency: 3 cycles per element plus 2-cycle start and end tokens. Every channel stalls indefinitely on !ready or !src_valid, holding its data.
module filter_loader #(
  parameter int WIDTH_data = 8,
  parameter int WIDTH_addr = 12,
  parameter int DEPTH_F    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  src_valid,
  input  logic [WIDTH_data-1:0] src_data,
  output logic                  src_ready,
  output logic                  ls_valid,
  input  logic                  ls_ready,
  output logic                  fa_valid,
  output logic [WIDTH_addr-1:0] fa_data,
  input  logic                  fa_ready,
  output logic                  fd_valid,
  output logic [WIDTH_data-1:0] fd_data,
  input  logic                  fd_ready,
  output logic                  ld_valid,
  input  logic                  ld_ready,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH_addr-1:0] elem_cnt
);

  localparam int                  N_ELEM    = DEPTH_F * DEPTH_F;
  localparam logic [WIDTH_addr-1:0] LAST_ADDR = WIDTH_addr'(N_ELEM - 1);
  localparam logic [WIDTH_addr-1:0] ONE       = WIDTH_addr'(1);

  typedef enum logic [2:0] {IDLE, LS, FETCH, ADDR, DATA, LD} state_t;

  state_t                  state;
  logic [WIDTH_addr-1:0]   addr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      src_ready <= 1'b0;
      ls_valid  <= 1'b0;
      fa_valid  <= 1'b0;
      fa_data   <= '0;
      fd_valid  <= 1'b0;
      fd_data   <= '0;
      ld_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      elem_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished load.
          if (start && !done) begin
            busy     <= 1'b1;
            ls_valid <= 1'b1;
            elem_cnt <= '0;
            addr_cnt <= '0;
            state    <= LS;
          end
        end
        LS: begin
          if (ls_ready) begin
            ls_valid  <= 1'b0;
            src_ready <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (src_valid) begin
            fd_data   <= src_data;
            fa_data   <= addr_cnt;
            fa_valid  <= 1'b1;
            src_ready <= 1'b0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (fa_ready) begin
            fa_valid <= 1'b0;
            fd_valid <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (fd_ready) begin
            fd_valid <= 1'b0;
            elem_cnt <= elem_cnt + ONE;
            if (addr_cnt == LAST_ADDR) begin
              ld_valid <= 1'b1;
              state    <= LD;
            end else begin
              addr_cnt  <= addr_cnt + ONE;
              src_ready <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        LD: begin
          if (ld_ready) begin
            ld_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_loader.sv
// Directed bench for filter_loader: full load, stalls, starvation, start filtering, reset mid-load.
module tb_filter_loader;

  localparam int WD = 8;
  localparam int WA = 12;
  localparam int NE = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic [WD-1:0] src_data = '0;
  logic          src_ready;
  logic          ls_valid, fa_valid, fd_valid, ld_valid;
  logic          ls_ready = 1'b0, fa_ready = 1'b0, fd_ready = 1'b0, ld_ready = 1'b0;
  logic [WA-1:0] fa_data;
  logic [WD-1:0] fd_data;
  logic          busy, done;
  logic [WA-1:0] elem_cnt;

  filter_loader #(.WIDTH_data(WD), .WIDTH_addr(WA), .DEPTH_F(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ls_valid(ls_valid), .ls_ready(ls_ready),
    .fa_valid(fa_valid), .fa_data(fa_data), .fa_ready(fa_ready),
    .fd_valid(fd_valid), .fd_data(fd_data), .fd_ready(fd_ready),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .busy(busy), .done(done), .elem_cnt(elem_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log: edge indices are those of the rising edge on which the handshake completes.
  int            src_e[$], fa_e[$], fd_e[$];
  logic [WA-1:0] fa_q[$];
  logic [WD-1:0] fd_q[$];
  int            ls_cnt, ld_cnt, ls_e, ld_e, done_cnt, done_e, src_cnt;

  logic          p_ok = 1'b0;
  logic          p_ls_v, p_ls_r, p_fa_v, p_fa_r, p_fd_v, p_fd_r, p_ld_v, p_ld_r;
  logic [WA-1:0] p_fa_d;
  logic [WD-1:0] p_fd_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ok = 1'b0;
    end else begin
      n_checks++;
      if ($countones({ls_valid, fa_valid, fd_valid, ld_valid}) > 1) begin
        n_fail++;
        $display("FAIL onehot t=%0t valids ls/fa/fd/ld=%b%b%b%b, required at most one", $time,
                 ls_valid, fa_valid, fd_valid, ld_valid);
      end
      if (p_ok) begin
        n_checks++;
        if ((p_ls_v && !p_ls_r && !ls_valid) ||
            (p_fa_v && !p_fa_r && (!fa_valid || fa_data !== p_fa_d)) ||
            (p_fd_v && !p_fd_r && (!fd_valid || fd_data !== p_fd_d)) ||
            (p_ld_v && !p_ld_r && !ld_valid)) begin
          n_fail++;
          $display("FAIL stable t=%0t valid/data changed before transfer: fa %b/%0d fd %b/%0d, required fa %b/%0d fd %b/%0d",
                   $time, fa_valid, fa_data, fd_valid, fd_data, p_fa_v, p_fa_d, p_fd_v, p_fd_d);
        end
      end
      if (ls_valid && ls_ready) begin ls_cnt++; ls_e = cyc + 1; end
      if (src_valid && src_ready) begin src_e.push_back(cyc + 1); src_cnt++; end
      if (fa_valid && fa_ready) begin fa_q.push_back(fa_data); fa_e.push_back(cyc + 1); end
      if (fd_valid && fd_ready) begin fd_q.push_back(fd_data); fd_e.push_back(cyc + 1); end
      if (ld_valid && ld_ready) begin ld_cnt++; ld_e = cyc + 1; end
      if (done) begin done_cnt++; done_e = cyc; end
      p_ls_v = ls_valid; p_ls_r = ls_ready; p_fa_v = fa_valid; p_fa_r = fa_ready; p_fa_d = fa_data;
      p_fd_v = fd_valid; p_fd_r = fd_ready; p_fd_d = fd_data; p_ld_v = ld_valid; p_ld_r = ld_ready;
      p_ok = 1'b1;
    end
  end

  task automatic clear_mon();
    src_e.delete(); fa_e.delete(); fd_e.delete(); fa_q.delete(); fd_q.delete();
    ls_cnt = 0; ld_cnt = 0; ls_e = -1; ld_e = -1; done_cnt = 0; done_e = -1; src_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bytes run 10, 11, ... in capture order; an idle source shows a marker byte.
  task automatic drive_src();
    src_data = src_valid ? WD'(10 + src_cnt) : 8'hEE;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_checks++;
    if ({ls_valid, fa_valid, fd_valid, ld_valid, src_ready, busy, done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags got %b required 0000000", {ls_valid, fa_valid, fd_valid, ld_valid, src_ready, busy, done});
    end
    n_checks++;
    if (fa_data !== '0 || fd_data !== '0 || elem_cnt !== '0) begin
      n_fail++; $display("FAIL reset_data fa=%0d fd=%0d cnt=%0d required 0", fa_data, fd_data, elem_cnt);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (ls_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle ls=%b busy=%b required 0 0", ls_valid, busy);
    end
  endtask

  task automatic test_full_load();
    int e0;
    clear_mon();
    ls_ready = 1; fa_ready = 1; fd_ready = 1; ld_ready = 1; src_valid = 1; drive_src();
    start = 1; step(); e0 = cyc; start = 0; drive_src();
    n_checks++;
    if (ls_valid !== 1'b1 || busy !== 1'b1 || elem_cnt !== '0) begin
      n_fail++; $display("FAIL full_start ls=%b busy=%b cnt=%0d required 1 1 0", ls_valid, busy, elem_cnt);
    end
    for (int k = 0; k < 150 && ld_cnt < 1; k++) begin
      step(); drive_src();
      if (cyc < e0 + 77) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy edge %0d busy=%b required 1", cyc - e0, busy); end
      end
    end
    n_checks++;
    if (ld_cnt !== 1) begin n_fail++; $display("FAIL full_timeout ld_cnt=%0d required 1", ld_cnt); end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || elem_cnt !== WA'(NE)) begin
      n_fail++; $display("FAIL full_end done=%b busy=%b cnt=%0d required 1 0 25", done, busy, elem_cnt);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || done_cnt !== 1 || done_e !== e0 + 77) begin
      n_fail++; $display("FAIL full_done done=%b count=%0d at %0d required 0 1 at 77", done, done_cnt, done_e - e0);
    end
    n_checks++;
    if (ls_e !== e0 + 1 || ld_e !== e0 + 77) begin
      n_fail++; $display("FAIL full_tokens ls at %0d ld at %0d required 1 and 77", ls_e - e0, ld_e - e0);
    end
    n_checks++;
    if (fa_q.size() !== NE || fd_q.size() !== NE || src_e.size() !== NE) begin
      n_fail++; $display("FAIL full_count fa=%0d fd=%0d src=%0d required 25", fa_q.size(), fd_q.size(), src_e.size());
    end else begin
      for (int i = 0; i < NE; i++) begin
        n_checks++;
        if (fa_q[i] !== WA'(i) || fd_q[i] !== WD'(10 + i)) begin
          n_fail++; $display("FAIL full_elem%0d addr=%0d data=%0d required %0d %0d", i, fa_q[i], fd_q[i], i, 10 + i);
        end
        n_checks++;
        if (src_e[i] !== e0 + 2 + 3 * i || fa_e[i] !== e0 + 3 + 3 * i || fd_e[i] !== e0 + 4 + 3 * i) begin
          n_fail++; $display("FAIL full_time%0d src/fa/fd at %0d/%0d/%0d required %0d/%0d/%0d", i,
                             src_e[i] - e0, fa_e[i] - e0, fd_e[i] - e0, 2 + 3 * i, 3 + 3 * i, 4 + 3 * i);
        end
      end
    end
  endtask

  task automatic test_fd_stall();
    int e0;
    clear_mon();
    src_valid = 1; drive_src();
    start = 1; step(); e0 = cyc; start = 0;
    for (int k = 0; k < 150 && ld_cnt < 1; k++) begin
      step();
      fd_ready = !(cyc >= e0 + 24 && cyc < e0 + 29);
      drive_src();
      if (cyc >= e0 + 25 && cyc <= e0 + 29) begin
        n_checks++;
        if (fd_valid !== 1'b1 || fd_data !== 8'd17 || src_ready !== 1'b0 || fa_valid !== 1'b0) begin
          n_fail++; $display("FAIL stall_hold edge %0d fd=%b/%0d src_rdy=%b fa=%b required 1/17 0 0",
                             cyc - e0, fd_valid, fd_data, src_ready, fa_valid);
        end
      end
    end
    fd_ready = 1;
    step();
    n_checks++;
    if (fd_q.size() !== NE || fa_q.size() !== NE) begin
      n_fail++; $display("FAIL stall_count fa=%0d fd=%0d required 25", fa_q.size(), fd_q.size());
    end else begin
      n_checks++;
      if (fa_e[7] !== e0 + 24 || fd_e[7] !== e0 + 30 || src_e[8] !== e0 + 31 || fd_q[7] !== 8'd17) begin
        n_fail++; $display("FAIL stall_elem7 fa at %0d fd at %0d next src at %0d data %0d required 24 30 31 17",
                           fa_e[7] - e0, fd_e[7] - e0, src_e[8] - e0, fd_q[7]);
      end
      for (int i = 0; i < NE; i++) begin
        n_checks++;
        if (fa_q[i] !== WA'(i) || fd_q[i] !== WD'(10 + i)) begin
          n_fail++; $display("FAIL stall_elem%0d addr=%0d data=%0d required %0d %0d", i, fa_q[i], fd_q[i], i, 10 + i);
        end
      end
    end
    n_checks++;
    if (ld_e !== e0 + 82 || done_e !== e0 + 82 || elem_cnt !== WA'(NE)) begin
      n_fail++; $display("FAIL stall_end ld at %0d done at %0d cnt=%0d required 82 82 25", ld_e - e0, done_e - e0, elem_cnt);
    end
  endtask

  task automatic test_src_starve();
    int e0;
    clear_mon();
    src_valid = 0; drive_src();
    start = 1; step(); e0 = cyc; start = 0;
    for (int k = 0; k < 150 && ld_cnt < 1; k++) begin
      step();
      src_valid = (cyc >= e0 + 4);
      drive_src();
      if (cyc >= e0 + 1 && cyc <= e0 + 4) begin
        n_checks++;
        if (src_ready !== 1'b1 || fa_valid !== 1'b0) begin
          n_fail++; $display("FAIL starve_wait edge %0d src_rdy=%b fa=%b required 1 0", cyc - e0, src_ready, fa_valid);
        end
      end
    end
    step();
    n_checks++;
    if (src_e.size() !== NE || fd_q.size() !== NE) begin
      n_fail++; $display("FAIL starve_count src=%0d fd=%0d required 25", src_e.size(), fd_q.size());
    end else begin
      n_checks++;
      if (src_e[0] !== e0 + 5 || fa_q[0] !== '0 || fd_q[0] !== 8'd10) begin
        n_fail++; $display("FAIL starve_first capture at %0d addr=%0d data=%0d required 5 0 10", src_e[0] - e0, fa_q[0], fd_q[0]);
      end
      for (int i = 1; i < NE; i++) begin
        n_checks++;
        if (fa_q[i] !== WA'(i) || fd_q[i] !== WD'(10 + i)) begin
          n_fail++; $display("FAIL starve_elem%0d addr=%0d data=%0d required %0d %0d", i, fa_q[i], fd_q[i], i, 10 + i);
        end
      end
    end
    n_checks++;
    if (ld_e !== e0 + 80) begin n_fail++; $display("FAIL starve_ld at %0d required 80", ld_e - e0); end
  endtask

  task automatic test_back_to_back();
    int e0;
    clear_mon();
    src_valid = 1; drive_src();
    start = 1; step(); e0 = cyc; start = 0;
    for (int k = 0; k < 150 && ld_cnt < 1; k++) begin
      step();
      start = (cyc == e0 + 16) || (cyc >= e0 + 76);
      drive_src();
    end
    n_checks++;
    if (done !== 1'b1 || ls_valid !== 1'b0 || busy !== 1'b0 || ls_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_done done=%b ls=%b busy=%b ls_cnt=%0d required 1 0 0 1", done, ls_valid, busy, ls_cnt);
    end
    step(); drive_src();
    n_checks++;
    if (done !== 1'b0 || ls_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap done=%b ls=%b busy=%b required 0 0 0", done, ls_valid, busy);
    end
    step(); drive_src();
    n_checks++;
    if (ls_valid !== 1'b1 || busy !== 1'b1 || elem_cnt !== '0 || cyc !== e0 + 79) begin
      n_fail++; $display("FAIL b2b_restart ls=%b busy=%b cnt=%0d edge %0d required 1 1 0 79", ls_valid, busy, elem_cnt, cyc - e0);
    end
    start = 0;
    for (int k = 0; k < 150 && ld_cnt < 2; k++) begin step(); drive_src(); end
    step();
    n_checks++;
    if (ls_cnt !== 2 || ld_cnt !== 2 || done_cnt !== 2 || ld_e !== e0 + 156) begin
      n_fail++; $display("FAIL b2b_tokens ls=%0d ld=%0d done=%0d ld at %0d required 2 2 2 156", ls_cnt, ld_cnt, done_cnt, ld_e - e0);
    end
    n_checks++;
    if (fa_q.size() !== 2 * NE || fd_q.size() !== 2 * NE) begin
      n_fail++; $display("FAIL b2b_count fa=%0d fd=%0d required 50", fa_q.size(), fd_q.size());
    end else begin
      for (int i = 0; i < 2 * NE; i++) begin
        n_checks++;
        if (fa_q[i] !== WA'(i % NE) || fd_q[i] !== WD'(10 + i)) begin
          n_fail++; $display("FAIL b2b_elem%0d addr=%0d data=%0d required %0d %0d", i, fa_q[i], fd_q[i], i % NE, 10 + i);
        end
      end
    end
    n_checks++;
    if (elem_cnt !== WA'(NE)) begin n_fail++; $display("FAIL b2b_cnt cnt=%0d required 25", elem_cnt); end
  endtask

  task automatic test_reset_mid_load();
    int e0;
    clear_mon();
    src_valid = 1; drive_src();
    start = 1; step(); e0 = cyc; start = 0;
    for (int k = 0; k < 60 && cyc < e0 + 38; k++) begin step(); drive_src(); end
    n_checks++;
    if (fa_valid !== 1'b1 || fa_data !== WA'(12) || fd_data !== 8'd22) begin
      n_fail++; $display("FAIL rst_pre fa=%b/%0d fd_data=%0d required 1/12 22", fa_valid, fa_data, fd_data);
    end
    fa_ready = 0;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({ls_valid, fa_valid, fd_valid, ld_valid, src_ready, busy, done} !== 7'b0 ||
        fa_data !== '0 || fd_data !== '0 || elem_cnt !== '0) begin
      n_fail++; $display("FAIL rst_async flags=%b fa=%0d fd=%0d cnt=%0d required all 0",
                         {ls_valid, fa_valid, fd_valid, ld_valid, src_ready, busy, done}, fa_data, fd_data, elem_cnt);
    end
    step(); step();
    rst_n = 1; fa_ready = 1;
    step(); step(); step();
    n_checks++;
    if (ld_cnt !== 0 || ld_valid !== 1'b0 || busy !== 1'b0 || ls_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_abandon ld_cnt=%0d ld=%b busy=%b ls=%b required 0 0 0 0", ld_cnt, ld_valid, busy, ls_valid);
    end
    clear_mon(); drive_src();
    start = 1; step(); e0 = cyc; start = 0;
    for (int k = 0; k < 150 && ld_cnt < 1; k++) begin step(); drive_src(); end
    step();
    n_checks++;
    if (ls_e !== e0 + 1 || ld_e !== e0 + 77 || elem_cnt !== WA'(NE)) begin
      n_fail++; $display("FAIL rst_fresh ls at %0d ld at %0d cnt=%0d required 1 77 25", ls_e - e0, ld_e - e0, elem_cnt);
    end
    n_checks++;
    if (fa_q.size() !== NE || fd_q.size() !== NE) begin
      n_fail++; $display("FAIL rst_count fa=%0d fd=%0d required 25", fa_q.size(), fd_q.size());
    end else begin
      for (int i = 0; i < NE; i++) begin
        n_checks++;
        if (fa_q[i] !== WA'(i) || fd_q[i] !== WD'(10 + i)) begin
          n_fail++; $display("FAIL rst_elem%0d addr=%0d data=%0d required %0d %0d", i, fa_q[i], fd_q[i], i, 10 + i);
        end
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_load();
    test_fd_stall();
    test_src_starve();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation exceeded 50000 ns, required completion");
    $fatal(1, "watchdog");
  end

endmodule
